// File: rtl/ibex_xif_dside_access_tracker_pkg.sv
// Shared types for the data-side access tracker and its downstream checker.
package ibex_xif_dside_access_tracker_pkg;

  // One completed data-side access, as forwarded to the ISS.
  typedef struct packed {
    logic        store;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        err;
    logic        mis_first;
    logic        mis_second;
  } dside_acc_t;

  // Request fields captured at grant time and held until the response.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        mis_first;
    logic        mis_second;
  } dside_req_t;

  // Fields that must stay stable while a request waits for its grant.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dside_req_snap_t;

  typedef enum logic [1:0] {
    PROTO_OK        = 2'd0,
    PROTO_OVERFLOW  = 2'd1,
    PROTO_UNDERFLOW = 2'd2,
    PROTO_UNSTABLE  = 2'd3
  } proto_err_e;

endpackage

// File: rtl/ibex_xif_dv_req_fifo.sv
// Parameterised synchronous FIFO with occupancy counter; a push alongside a
// pop is accepted even when full, pushes while full otherwise are dropped.
module ibex_xif_dv_req_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop_ok) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset flushes every entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ibex_xif_dside_access_tracker.sv
// Observes the Ibex data-side bus and emits one record per completed access,
// with in-order matching of responses to granted requests and sticky
// protocol-violation reporting.
module ibex_xif_dside_access_tracker
  import ibex_xif_dside_access_tracker_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        host_dmem_req,
  input  logic        host_dmem_gnt,
  input  logic        host_dmem_we,
  input  logic [31:0] host_dmem_addr,
  input  logic [3:0]  host_dmem_be,
  input  logic [31:0] host_dmem_wdata,
  input  logic        misaligned_first_i,
  input  logic        misaligned_second_i,
  input  logic        host_dmem_rvalid,
  input  logic [31:0] host_dmem_rdata,
  input  logic        host_dmem_err,
  output logic        acc_valid_o,
  output logic        acc_store_o,
  output logic [31:0] acc_addr_o,
  output logic [3:0]  acc_be_o,
  output logic [31:0] acc_data_o,
  output logic        acc_err_o,
  output logic        acc_misaligned_first_o,
  output logic        acc_misaligned_second_o,
  output logic [3:0]  outstanding_o,
  output logic        proto_err_o,
  output logic [1:0]  proto_err_code_o
);

  dside_req_t      push_entry, head;
  dside_req_snap_t cur_snap, snap_q, snap_d;
  dside_acc_t      acc_q, acc_d;
  proto_err_e      code_q, code_d;
  logic            pending_q, pending_d;
  logic            acc_valid_q, acc_valid_d;
  logic            push, pop, full, empty;
  logic            underflow, overflow, unstable;

  assign push = host_dmem_req && host_dmem_gnt;
  assign pop  = host_dmem_rvalid && !empty;

  assign push_entry = '{we:         host_dmem_we,
                        addr:       host_dmem_addr,
                        be:         host_dmem_be,
                        wdata:      host_dmem_wdata,
                        mis_first:  misaligned_first_i,
                        mis_second: misaligned_second_i};

  assign cur_snap = '{we:    host_dmem_we,
                      addr:  host_dmem_addr,
                      be:    host_dmem_be,
                      wdata: host_dmem_wdata};

  ibex_xif_dv_req_fifo #(
    .Width ($bits(dside_req_t)),
    .Depth (MaxOutstanding),
    .CntW  (4)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (host_dmem_rvalid),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  // A grant in the same cycle cannot satisfy an rvalid, so emptiness is
  // judged on registered occupancy alone.
  assign underflow = host_dmem_rvalid && empty;
  assign overflow  = push && full && !pop;
  assign unstable  = pending_q && host_dmem_req && (cur_snap != snap_q);

  // Stability monitor, sticky first-error capture and record formation.
  always_comb begin
    pending_d = host_dmem_req && !host_dmem_gnt;
    snap_d    = pending_d ? cur_snap : snap_q;

    code_d = code_q;
    if (code_q == PROTO_OK) begin
      if (underflow)     code_d = PROTO_UNDERFLOW;
      else if (overflow) code_d = PROTO_OVERFLOW;
      else if (unstable) code_d = PROTO_UNSTABLE;
    end

    acc_valid_d = pop;
    acc_d       = acc_q;
    if (pop) begin
      acc_d.store      = head.we;
      acc_d.addr       = head.addr;
      acc_d.be         = head.be;
      acc_d.data       = head.we ? head.wdata : host_dmem_rdata;
      acc_d.err        = host_dmem_err;
      acc_d.mis_first  = head.mis_first;
      acc_d.mis_second = head.mis_second;
    end
  end

  // Monitor, error and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q   <= 1'b0;
      snap_q      <= '0;
      code_q      <= PROTO_OK;
      acc_valid_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      snap_q      <= snap_d;
      code_q      <= code_d;
      acc_valid_q <= acc_valid_d;
      acc_q       <= acc_d;
    end
  end

  assign acc_valid_o             = acc_valid_q;
  assign acc_store_o             = acc_q.store;
  assign acc_addr_o              = acc_q.addr;
  assign acc_be_o                = acc_q.be;
  assign acc_data_o              = acc_q.data;
  assign acc_err_o               = acc_q.err;
  assign acc_misaligned_first_o  = acc_q.mis_first;
  assign acc_misaligned_second_o = acc_q.mis_second;
  assign proto_err_o             = (code_q != PROTO_OK);
  assign proto_err_code_o        = code_q;

endmodule

// File: tb/tb_ibex_xif_dside_access_tracker.sv
// Directed bench for the data-side access tracker with hand-computed records.
module tb_ibex_xif_dside_access_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        mf, ms;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rerr;

  logic        acc_valid, acc_store, acc_err, acc_mf, acc_ms;
  logic [31:0] acc_addr, acc_data;
  logic [3:0]  acc_be;
  logic [3:0]  outstanding;
  logic        proto_err;
  logic [1:0]  proto_code;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  ibex_xif_dside_access_tracker #(.MaxOutstanding(2)) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .host_dmem_req           (req),
    .host_dmem_gnt           (gnt),
    .host_dmem_we            (we),
    .host_dmem_addr          (addr),
    .host_dmem_be            (be),
    .host_dmem_wdata         (wdata),
    .misaligned_first_i      (mf),
    .misaligned_second_i     (ms),
    .host_dmem_rvalid        (rvalid),
    .host_dmem_rdata         (rdata),
    .host_dmem_err           (rerr),
    .acc_valid_o             (acc_valid),
    .acc_store_o             (acc_store),
    .acc_addr_o              (acc_addr),
    .acc_be_o                (acc_be),
    .acc_data_o              (acc_data),
    .acc_err_o               (acc_err),
    .acc_misaligned_first_o  (acc_mf),
    .acc_misaligned_second_o (acc_ms),
    .outstanding_o           (outstanding),
    .proto_err_o             (proto_err),
    .proto_err_code_o        (proto_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic f, input logic s);
    req = 1'b1; gnt = 1'b1; we = w; addr = a; be = b; wdata = d; mf = f; ms = s;
  endtask

  task automatic clr_req();
    req = 1'b0; gnt = 1'b0; we = 1'b0; mf = 1'b0; ms = 1'b0;
  endtask

  task automatic grant(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic f, input logic s);
    set_req(w, a, b, d, f, s);
    step();
    clr_req();
  endtask

  task automatic resp(input logic [31:0] d, input logic e);
    rvalid = 1'b1; rdata = d; rerr = e;
    step();
    rvalid = 1'b0; rerr = 1'b0;
  endtask

  task automatic check_rec(input string tag, input logic s, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d, input logic e,
                           input logic f, input logic sec);
    check_eq({tag, "_valid"}, acc_valid, 1);
    check_eq({tag, "_store"}, acc_store, s);
    check_eq({tag, "_addr"},  acc_addr,  a);
    check_eq({tag, "_be"},    acc_be,    b);
    check_eq({tag, "_data"},  acc_data,  d);
    check_eq({tag, "_err"},   acc_err,   e);
    check_eq({tag, "_mf"},    acc_mf,    f);
    check_eq({tag, "_ms"},    acc_ms,    sec);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, acc_valid, 0);
    check_eq({tag, "_store"}, acc_store, 0);
    check_eq({tag, "_addr"},  acc_addr, 0);
    check_eq({tag, "_be"},    acc_be, 0);
    check_eq({tag, "_data"},  acc_data, 0);
    check_eq({tag, "_err"},   acc_err, 0);
    check_eq({tag, "_mf"},    acc_mf, 0);
    check_eq({tag, "_ms"},    acc_ms, 0);
    check_eq({tag, "_occ"},   outstanding, 0);
    check_eq({tag, "_perr"},  proto_err, 0);
    check_eq({tag, "_code"},  proto_code, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    req = 0; gnt = 0; we = 0; addr = '0; be = '0; wdata = '0; mf = 0; ms = 0;
    rvalid = 0; rdata = '0; rerr = 0;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Single load
    grant(1'b0, 32'h0010_0004, 4'hF, 32'h0, 1'b0, 1'b0);
    check_eq("ld_occ1", outstanding, 1);
    step();
    check_eq("ld_occ1b", outstanding, 1);
    check_eq("ld_novalid", acc_valid, 0);
    resp(32'hDEAD_BEEF, 1'b0);
    check_rec("ld", 1'b0, 32'h0010_0004, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check_eq("ld_occ0", outstanding, 0);
    step();
    check_eq("ld_pulse", acc_valid, 0);
    check_eq("ld_hold", acc_data, 32'hDEAD_BEEF);

    // Two outstanding, back-to-back responses
    grant(1'b1, 32'h0000_0100, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
    check_eq("two_occ1", outstanding, 1);
    grant(1'b0, 32'h0000_0104, 4'h3, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("two_occ2", outstanding, 2);
    rvalid = 1'b1; rdata = 32'hAAAA_0000;
    step();
    check_rec("two_st", 1'b1, 32'h0000_0100, 4'hF, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    check_eq("two_occ1b", outstanding, 1);
    rdata = 32'h0BAD_F00D;
    step();
    rvalid = 1'b0;
    check_rec("two_ld", 1'b0, 32'h0000_0104, 4'h3, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    check_eq("two_occ0", outstanding, 0);
    check_eq("two_perr", proto_err, 0);

    // Full plus simultaneous push/pop, then overflow
    grant(1'b0, 32'h0000_0400, 4'hF, 32'h0, 1'b0, 1'b0);
    grant(1'b0, 32'h0000_0404, 4'hF, 32'h0, 1'b0, 1'b0);
    check_eq("full_occ2", outstanding, 2);
    set_req(1'b0, 32'h0000_0408, 4'hF, 32'h0, 1'b0, 1'b0);
    rvalid = 1'b1; rdata = 32'h1111_1111;
    step();
    clr_req(); rvalid = 1'b0;
    check_rec("sim", 1'b0, 32'h0000_0400, 4'hF, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    check_eq("sim_occ2", outstanding, 2);
    check_eq("sim_perr", proto_err, 0);
    grant(1'b0, 32'h0000_040C, 4'hF, 32'h0, 1'b0, 1'b0);
    check_eq("ovf_perr", proto_err, 1);
    check_eq("ovf_code", proto_code, 1);
    check_eq("ovf_occ2", outstanding, 2);
    resp(32'h2222_2222, 1'b0);
    check_rec("ovf_r1", 1'b0, 32'h0000_0404, 4'hF, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    resp(32'h3333_3333, 1'b0);
    check_rec("ovf_r2", 1'b0, 32'h0000_0408, 4'hF, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    check_eq("ovf_occ0", outstanding, 0);
    do_reset();
    check_all_zero("rst2");

    // Underflow with a grant in the same cycle, then overflow keeps code 2
    set_req(1'b0, 32'h0000_0500, 4'hF, 32'h0, 1'b0, 1'b0);
    rvalid = 1'b1; rdata = 32'h5555_5555;
    step();
    clr_req(); rvalid = 1'b0;
    check_eq("unf_novalid", acc_valid, 0);
    check_eq("unf_code", proto_code, 2);
    check_eq("unf_occ1", outstanding, 1);
    grant(1'b0, 32'h0000_0504, 4'hF, 32'h0, 1'b0, 1'b0);
    grant(1'b0, 32'h0000_0508, 4'hF, 32'h0, 1'b0, 1'b0);
    check_eq("unf_ovf_occ", outstanding, 2);
    check_eq("unf_code_kept", proto_code, 2);
    resp(32'h6666_6666, 1'b0);
    check_rec("unf_r1", 1'b0, 32'h0000_0500, 4'hF, 32'h6666_6666, 1'b0, 1'b0, 1'b0);
    resp(32'h7777_7777, 1'b0);
    check_rec("unf_r2", 1'b0, 32'h0000_0504, 4'hF, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Misaligned split access with error on the second half
    grant(1'b0, 32'h0000_0201, 4'hE, 32'h0, 1'b1, 1'b0);
    grant(1'b0, 32'h0000_0204, 4'h1, 32'h0, 1'b0, 1'b1);
    resp(32'hCAFE_0001, 1'b0);
    check_rec("mis1", 1'b0, 32'h0000_0201, 4'hE, 32'hCAFE_0001, 1'b0, 1'b1, 1'b0);
    resp(32'hCAFE_0002, 1'b1);
    check_rec("mis2", 1'b0, 32'h0000_0204, 4'h1, 32'hCAFE_0002, 1'b1, 1'b0, 1'b1);
    check_eq("mis_perr", proto_err, 0);

    // Unstable request, then reset with one entry in flight
    req = 1'b1; gnt = 1'b0; we = 1'b0; addr = 32'h0000_0300; be = 4'hF; wdata = '0;
    step();
    check_eq("uns_none_yet", proto_err, 0);
    addr = 32'h0000_0304;
    step();
    check_eq("uns_perr", proto_err, 1);
    check_eq("uns_code", proto_code, 3);
    gnt = 1'b1;
    step();
    clr_req();
    check_eq("uns_occ1", outstanding, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    rst_n = 1'b1;
    step();
    resp(32'h8888_8888, 1'b0);
    check_eq("post_rst_novalid", acc_valid, 0);
    check_eq("post_rst_code", proto_code, 2);
    check_eq("post_rst_occ", outstanding, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
